key_scan: RTL

Keypad scanner for the 4-column x 5-row key matrix. It drives one column low at a time and samples the 5 active-low row lines. It debounces the decoded key over whole scan frames and presents a 5-bit key code with a one-cycle press strobe. It sits between the keypad (or the keypad simulation model) and the segment-display logic, on the 10 MHz system clock.

---
 rtl/key_scan.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/key_scan.sv
// 4x5 keypad scanner: column drive, per-frame decode, frame-level press/release debounce.
// Optional KEY_SCAN_MULTI_EN adds key_multi and treats multi-key frames as "no key".
module key_scan #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] key_column_out,
  input  logic [4:0] key_row_in,
  output logic [4:0] key_code,
  output logic       key_valid,
  output logic       key_hold
`ifdef KEY_SCAN_MULTI_EN
  ,
  output logic       key_multi
`endif
);

  // state       | meaning
  // RELEASED    | no key accepted, waiting for a key frame
  // PRESS_CHK   | candidate key seen, counting agreeing frames
  // PRESSED     | key accepted and held
  // RELEASE_CHK | accepted key missing, counting release frames
  typedef enum logic [1:0] {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK} state_t;

  localparam int unsigned   DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]    DEB        = 4'(DEBOUNCE);

  state_t        state;
  logic [3:0]    cnt;
  logic [4:0]    cand;
  logic [DW-1:0] dwell;
  logic [1:0]    col;
  logic          sample, frame_end;

  logic [4:0]    row_low;
  logic [2:0]    row_idx;
  logic          col_any;
  logic [4:0]    col_code;
  logic          acc_any, prev_any, f_any;
  logic [4:0]    acc_code, f_code;
  logic          res_key, res_is_cur, res_is_cand;

  assign sample    = (dwell == DWELL_LAST);
  assign frame_end = sample && (col == 2'd3);

  always_comb begin
    row_low = ~key_row_in;
    row_idx = 3'd0;
    for (int r = 4; r >= 0; r--) begin
      if (row_low[r]) row_idx = 3'(r);
    end
  end

  assign col_any  = |row_low;
  assign col_code = {3'b000, col} * 5'd5 + {2'b00, row_idx} + 5'd1;

  // Column 0 starts a new frame, so the accumulators are ignored there.
  assign prev_any = (col != 2'd0) && acc_any;
  assign f_any    = prev_any | col_any;
  assign f_code   = prev_any ? acc_code : col_code;

`ifdef KEY_SCAN_MULTI_EN
  logic acc_multi, col_multi, prev_multi, f_multi;
  assign col_multi  = |(row_low & (row_low - 5'd1));
  assign prev_multi = (col != 2'd0) && acc_multi;
  assign f_multi    = prev_multi | col_multi | (prev_any & col_any);
  assign res_key    = f_any & ~f_multi;
`else
  assign res_key    = f_any;
`endif

  assign res_is_cur  = res_key && (f_code == key_code);
  assign res_is_cand = res_key && (f_code == cand);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell          <= '0;
      col            <= 2'd0;
      key_column_out <= 4'b1110;
      acc_any        <= 1'b0;
      acc_code       <= 5'd0;
`ifdef KEY_SCAN_MULTI_EN
      acc_multi      <= 1'b0;
`endif
    end else if (sample) begin
      dwell          <= '0;
      col            <= col + 2'd1;
      key_column_out <= ~(4'b0001 << (col + 2'd1));
      acc_any        <= f_any;
      acc_code       <= f_code;
`ifdef KEY_SCAN_MULTI_EN
      acc_multi      <= f_multi;
`endif
    end else begin
      dwell <= dwell + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RELEASED;
      cnt       <= 4'd0;
      cand      <= 5'd0;
      key_code  <= 5'd0;
      key_valid <= 1'b0;
      key_hold  <= 1'b0;
`ifdef KEY_SCAN_MULTI_EN
      key_multi <= 1'b0;
`endif
    end else begin
      key_valid <= 1'b0;
`ifdef KEY_SCAN_MULTI_EN
      key_multi <= frame_end && f_multi;
`endif
      if (frame_end) begin
        case (state)
          RELEASED: begin
            if (res_key) begin
              if (DEB == 4'd1) begin
                key_code  <= f_code;
                key_valid <= 1'b1;
                key_hold  <= 1'b1;
                state     <= PRESSED;
              end else begin
                cand  <= f_code;
                cnt   <= 4'd1;
                state <= PRESS_CHK;
              end
            end
          end
          PRESS_CHK: begin
            if (res_is_cand) begin
              cnt <= cnt + 4'd1;
              if (cnt + 4'd1 == DEB) begin
                key_code  <= cand;
                key_valid <= 1'b1;
                key_hold  <= 1'b1;
                state     <= PRESSED;
              end
            end else if (res_key) begin
              cand <= f_code;
              cnt  <= 4'd1;
            end else begin
              state <= RELEASED;
            end
          end
          PRESSED: begin
            if (!res_is_cur) begin
              if (DEB == 4'd1) begin
                key_hold <= 1'b0;
                state    <= RELEASED;
              end else begin
                cnt   <= 4'd1;
                state <= RELEASE_CHK;
              end
            end
          end
          RELEASE_CHK: begin
            if (res_is_cur) begin
              state <= PRESSED;
            end else begin
              cnt <= cnt + 4'd1;
              if (cnt + 4'd1 == DEB) begin
                key_hold <= 1'b0;
                state    <= RELEASED;
              end
            end
          end
          default: state <= RELEASED;
        endcase
      end
    end
  end

endmodule
